// File: rtl/instn_decode_unit.sv
// instn_decode_unit: Alpha integer-subset instruction decoder with registered outputs.
// Decode is purely combinational; every output (and the debug mnemonic) is flopped once.
module instn_decode_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instn,
   output logic [6:0]  funit,
   output logic [4:0]  reg_a,
   output logic [4:0]  reg_b,
   output logic [4:0]  reg_dst,
   output logic [63:0] literal,
   output logic        no_rf_upd,
   output logic        use_ltrl_8,
   output logic        use_ltrl_16,
   output logic        use_ltrl_21,
   output logic [1:0]  addsub_op,
   output logic [1:0]  addsub_scale,
   output logic [2:0]  addsub_cmp_op,
   output logic [2:0]  log_op,
   output logic [2:0]  log_cmp_op,
   output logic        log_cond_upd,
   output logic [3:0]  ctu_op,
   output logic [2:0]  shmsk_op,
   output logic [1:0]  op_size,
   output logic [1:0]  mpu_op,
   output logic        lsu_op,
   output logic        op_llsc,
   output logic        cpr_op,
   output logic        e_reserved,
   output logic        e_halt,
   output logic        e_callpal,
   output logic        hw_ret
);
   typedef enum logic [6:0] {
      NONE, RESERVED, HALT, CALL_PAL, HW_MFPR, HW_MTPR, HW_RET,
      LDA, LDAH, LDBU, LDWU, LDL, LDQ, LDL_L, LDQ_L,
      STB, STW, STL, STQ, STL_C, STQ_C,
      ADDL, S4ADDL, SUBL, S4SUBL, S8ADDL, S8SUBL,
      ADDQ, S4ADDQ, SUBQ, S4SUBQ, S8ADDQ, S8SUBQ,
      CMPULT, CMPEQ, CMPULE, CMPLT, CMPLE,
      MULL, MULQ, UMULH,
      JMP, BR, BSR, BLBC, BEQ, BLT, BLE, BLBS, BNE, BGE, BGT,
      AND, BIC, BIS, ORNOT, XOR, EQV,
      CMOVLBS, CMOVLBC, CMOVEQ, CMOVNE, CMOVLT, CMOVGE, CMOVLE, CMOVGT,
      MSKBL, MSKWL, MSKLL, MSKQL, EXTBL, EXTWL, EXTLL, EXTQL,
      INSBL, INSWL, INSLL, INSQL, ZAP, ZAPNOT, SRL, SLL, SRA
   } mnem_e;

   typedef struct packed {
      logic [6:0]  funit;
      logic [4:0]  reg_a;
      logic [4:0]  reg_b;
      logic [4:0]  reg_dst;
      logic [63:0] literal;
      logic        no_rf_upd;
      logic        use_ltrl_8;
      logic        use_ltrl_16;
      logic        use_ltrl_21;
      logic [1:0]  addsub_op;
      logic [1:0]  addsub_scale;
      logic [2:0]  addsub_cmp_op;
      logic [2:0]  log_op;
      logic [2:0]  log_cmp_op;
      logic        log_cond_upd;
      logic [3:0]  ctu_op;
      logic [2:0]  shmsk_op;
      logic [1:0]  op_size;
      logic [1:0]  mpu_op;
      logic        lsu_op;
      logic        op_llsc;
      logic        cpr_op;
   } dec_t;

   localparam dec_t DEC_IDLE = '{reg_a: 5'd31, reg_b: 5'd31, reg_dst: 5'd31, no_rf_upd: 1'b1, default: '0};
   localparam logic [6:0] F_ADDS = 7'h01, F_LOG = 7'h02, F_SHM = 7'h04, F_LSU = 7'h08;
   localparam logic [6:0] F_CTU = 7'h10, F_MPU = 7'h20, F_CPR = 7'h40;

   logic [5:0]  op;
   logic [6:0]  func;
   logic [4:0]  ra;
   logic [63:0] lit16, lit21;
   logic        rsv;
   dec_t        dec_d, dec_q;
   mnem_e       mnem_d, decoded_instn;

   assign op    = instn[31:26];
   assign func  = instn[11:5];
   assign ra    = instn[25:21];
   assign lit16 = {{48{instn[15]}}, instn[15:0]};
   assign lit21 = {{43{instn[20]}}, instn[20:0]};

   always_comb begin
      dec_d = DEC_IDLE;
      dec_d.reg_a = ra;
      dec_d.reg_b = instn[20:16];
      mnem_d = RESERVED;
      rsv = 1'b0;
      // Operate formats (0x10-0x13) share destination and 8-bit literal handling
      if (op[5:2] == 4'b0100) begin
         dec_d.reg_dst = instn[4:0];
         dec_d.no_rf_upd = 1'b0;
         dec_d.use_ltrl_8 = instn[12];
         dec_d.literal = instn[12] ? {56'd0, instn[20:13]} : 64'd0;
      end
      case (op)
         6'h00: mnem_d = (instn[25:0] == 26'd0) ? HALT : CALL_PAL;
         6'h08, 6'h09: begin
            mnem_d = op[0] ? LDAH : LDA;
            dec_d.funit = F_ADDS;
            dec_d.addsub_op = op[0] ? 2'd3 : 2'd0;
            dec_d.op_size = 2'd3;
            dec_d.reg_dst = ra;
            dec_d.no_rf_upd = 1'b0;
            dec_d.use_ltrl_16 = 1'b1;
            dec_d.literal = lit16;
         end
         6'h0A, 6'h0C, 6'h28, 6'h29, 6'h2A, 6'h2B: begin
            case (op)
               6'h0A: mnem_d = LDBU;
               6'h0C: mnem_d = LDWU;
               6'h28: mnem_d = LDL;
               6'h29: mnem_d = LDQ;
               6'h2A: mnem_d = LDL_L;
               default: mnem_d = LDQ_L;
            endcase
            dec_d.funit = F_LSU;
            dec_d.op_size = op[5] ? {1'b1, op[0]} : {1'b0, op[2]};
            dec_d.op_llsc = op[5] & op[1];
            dec_d.reg_dst = ra;
            dec_d.no_rf_upd = 1'b0;
            dec_d.use_ltrl_16 = 1'b1;
            dec_d.literal = lit16;
         end
         6'h0D, 6'h0E, 6'h2C, 6'h2D, 6'h2E, 6'h2F: begin
            case (op)
               6'h0E: mnem_d = STB;
               6'h0D: mnem_d = STW;
               6'h2C: mnem_d = STL;
               6'h2D: mnem_d = STQ;
               6'h2E: mnem_d = STL_C;
               default: mnem_d = STQ_C;
            endcase
            dec_d.funit = F_LSU;
            dec_d.lsu_op = 1'b1;
            dec_d.op_size = {op[5], op[0]};
            dec_d.op_llsc = op[5] & op[1];
            // Store-conditional returns its success flag in ra
            dec_d.reg_dst = dec_d.op_llsc ? ra : 5'd31;
            dec_d.no_rf_upd = !dec_d.op_llsc;
            dec_d.use_ltrl_16 = 1'b1;
            dec_d.literal = lit16;
         end
         6'h10: begin
            case (func)
               7'h00: mnem_d = ADDL;
               7'h02: mnem_d = S4ADDL;
               7'h09: mnem_d = SUBL;
               7'h0B: mnem_d = S4SUBL;
               7'h12: mnem_d = S8ADDL;
               7'h1B: mnem_d = S8SUBL;
               7'h20: mnem_d = ADDQ;
               7'h22: mnem_d = S4ADDQ;
               7'h29: mnem_d = SUBQ;
               7'h2B: mnem_d = S4SUBQ;
               7'h32: mnem_d = S8ADDQ;
               7'h3B: mnem_d = S8SUBQ;
               7'h1D: begin mnem_d = CMPULT; dec_d.addsub_cmp_op = 3'd3; end
               7'h2D: begin mnem_d = CMPEQ;  dec_d.addsub_cmp_op = 3'd0; end
               7'h3D: begin mnem_d = CMPULE; dec_d.addsub_cmp_op = 3'd4; end
               7'h4D: begin mnem_d = CMPLT;  dec_d.addsub_cmp_op = 3'd1; end
               7'h6D: begin mnem_d = CMPLE;  dec_d.addsub_cmp_op = 3'd2; end
               default: rsv = 1'b1;
            endcase
            dec_d.funit = F_ADDS;
            // Compares share the xxx1101 func pattern; scale comes from func[1]/func[4]
            dec_d.addsub_op = (func[3:0] == 4'hD) ? 2'd2 : {1'b0, func[3]};
            dec_d.addsub_scale = func[1] ? (func[4] ? 2'd2 : 2'd1) : 2'd0;
            dec_d.op_size = (func[5] || func[3:0] == 4'hD) ? 2'd3 : 2'd2;
         end
         6'h11: begin
            dec_d.funit = F_LOG;
            case (func)
               7'h00: begin mnem_d = AND;   dec_d.log_op = 3'd0; end
               7'h08: begin mnem_d = BIC;   dec_d.log_op = 3'd1; end
               7'h20: begin mnem_d = BIS;   dec_d.log_op = 3'd2; end
               7'h28: begin mnem_d = ORNOT; dec_d.log_op = 3'd3; end
               7'h40: begin mnem_d = XOR;   dec_d.log_op = 3'd4; end
               7'h48: begin mnem_d = EQV;   dec_d.log_op = 3'd5; end
               7'h14: begin mnem_d = CMOVLBS; dec_d.log_cmp_op = 3'd6; end
               7'h16: begin mnem_d = CMOVLBC; dec_d.log_cmp_op = 3'd7; end
               7'h24: begin mnem_d = CMOVEQ;  dec_d.log_cmp_op = 3'd0; end
               7'h26: begin mnem_d = CMOVNE;  dec_d.log_cmp_op = 3'd1; end
               7'h44: begin mnem_d = CMOVLT;  dec_d.log_cmp_op = 3'd2; end
               7'h46: begin mnem_d = CMOVGE;  dec_d.log_cmp_op = 3'd3; end
               7'h64: begin mnem_d = CMOVLE;  dec_d.log_cmp_op = 3'd4; end
               7'h66: begin mnem_d = CMOVGT;  dec_d.log_cmp_op = 3'd5; end
               default: rsv = 1'b1;
            endcase
            dec_d.log_cond_upd = func[2];
            dec_d.log_op = func[2] ? 3'd6 : dec_d.log_op;
         end
         6'h12: begin
            dec_d.funit = F_SHM;
            case (func)
               7'h02: mnem_d = MSKBL;
               7'h12: mnem_d = MSKWL;
               7'h22: mnem_d = MSKLL;
               7'h32: mnem_d = MSKQL;
               7'h06: mnem_d = EXTBL;
               7'h16: mnem_d = EXTWL;
               7'h26: mnem_d = EXTLL;
               7'h36: mnem_d = EXTQL;
               7'h0B: mnem_d = INSBL;
               7'h1B: mnem_d = INSWL;
               7'h2B: mnem_d = INSLL;
               7'h3B: mnem_d = INSQL;
               7'h30: begin mnem_d = ZAP;    dec_d.shmsk_op = 3'd6; end
               7'h31: begin mnem_d = ZAPNOT; dec_d.shmsk_op = 3'd7; end
               7'h34: begin mnem_d = SRL;    dec_d.shmsk_op = 3'd1; end
               7'h39: begin mnem_d = SLL;    dec_d.shmsk_op = 3'd0; end
               7'h3C: begin mnem_d = SRA;    dec_d.shmsk_op = 3'd2; end
               default: rsv = 1'b1;
            endcase
            // Byte-manipulation forms carry their size in func[5:4]
            if (func[3:0] == 4'h2 || func[3:0] == 4'h6 || func[3:0] == 4'hB) begin
               dec_d.shmsk_op = (func[3:0] == 4'h2) ? 3'd5 : (func[3:0] == 4'h6) ? 3'd3 : 3'd4;
               dec_d.op_size = func[5:4];
            end
         end
         6'h13: begin
            dec_d.funit = F_MPU;
            case (func)
               7'h00: begin mnem_d = MULL;  dec_d.mpu_op = 2'd0; end
               7'h20: begin mnem_d = MULQ;  dec_d.mpu_op = 2'd1; end
               7'h30: begin mnem_d = UMULH; dec_d.mpu_op = 2'd2; end
               default: rsv = 1'b1;
            endcase
         end
         6'h19: begin
            mnem_d = HW_MFPR;
            dec_d.funit = F_CPR;
            dec_d.reg_dst = ra;
            dec_d.no_rf_upd = 1'b0;
         end
         6'h1D: begin
            mnem_d = HW_MTPR;
            dec_d.funit = F_CPR;
            dec_d.cpr_op = 1'b1;
         end
         6'h1E: mnem_d = HW_RET;
         6'h1A: begin
            mnem_d = JMP;
            dec_d.funit = F_CTU;
            dec_d.ctu_op = 4'd1;
            dec_d.reg_dst = ra;
            dec_d.no_rf_upd = 1'b0;
         end
         6'h30, 6'h34: begin
            mnem_d = op[2] ? BSR : BR;
            dec_d.funit = F_CTU;
            dec_d.reg_dst = ra;
            dec_d.no_rf_upd = 1'b0;
            dec_d.use_ltrl_21 = 1'b1;
            dec_d.literal = lit21;
         end
         6'h38, 6'h39, 6'h3A, 6'h3B, 6'h3C, 6'h3D, 6'h3E, 6'h3F: begin
            dec_d.funit = F_CTU;
            dec_d.use_ltrl_21 = 1'b1;
            dec_d.literal = lit21;
            case (op[2:0])
               3'd0: begin mnem_d = BLBC; dec_d.ctu_op = 4'd8; end
               3'd1: begin mnem_d = BEQ;  dec_d.ctu_op = 4'd2; end
               3'd2: begin mnem_d = BLT;  dec_d.ctu_op = 4'd4; end
               3'd3: begin mnem_d = BLE;  dec_d.ctu_op = 4'd6; end
               3'd4: begin mnem_d = BLBS; dec_d.ctu_op = 4'd9; end
               3'd5: begin mnem_d = BNE;  dec_d.ctu_op = 4'd3; end
               3'd6: begin mnem_d = BGE;  dec_d.ctu_op = 4'd5; end
               default: begin mnem_d = BGT; dec_d.ctu_op = 4'd7; end
            endcase
         end
         default: rsv = 1'b1;
      endcase
      if (rsv) begin
         dec_d = DEC_IDLE;
         dec_d.reg_a = ra;
         dec_d.reg_b = instn[20:16];
         mnem_d = RESERVED;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dec_q <= DEC_IDLE;
         decoded_instn <= NONE;
      end else begin
         dec_q <= dec_d;
         decoded_instn <= mnem_d;
      end
   end

   assign funit         = dec_q.funit;
   assign reg_a         = dec_q.reg_a;
   assign reg_b         = dec_q.reg_b;
   assign reg_dst       = dec_q.reg_dst;
   assign literal       = dec_q.literal;
   assign no_rf_upd     = dec_q.no_rf_upd;
   assign use_ltrl_8    = dec_q.use_ltrl_8;
   assign use_ltrl_16   = dec_q.use_ltrl_16;
   assign use_ltrl_21   = dec_q.use_ltrl_21;
   assign addsub_op     = dec_q.addsub_op;
   assign addsub_scale  = dec_q.addsub_scale;
   assign addsub_cmp_op = dec_q.addsub_cmp_op;
   assign log_op        = dec_q.log_op;
   assign log_cmp_op    = dec_q.log_cmp_op;
   assign log_cond_upd  = dec_q.log_cond_upd;
   assign ctu_op        = dec_q.ctu_op;
   assign shmsk_op      = dec_q.shmsk_op;
   assign op_size       = dec_q.op_size;
   assign mpu_op        = dec_q.mpu_op;
   assign lsu_op        = dec_q.lsu_op;
   assign op_llsc       = dec_q.op_llsc;
   assign cpr_op        = dec_q.cpr_op;
   // Exception flags fall out of the registered mnemonic, so they are exclusive by construction
   assign e_reserved    = decoded_instn == RESERVED;
   assign e_halt        = decoded_instn == HALT;
   assign e_callpal     = decoded_instn == CALL_PAL;
   assign hw_ret        = decoded_instn == HW_RET;
endmodule

// File: tb/tb_instn_decode_unit.sv
// tb_instn_decode_unit: directed-vector bench for the Alpha instruction decoder.
module tb_instn_decode_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] instn = 32'd0;
   logic [6:0]  funit;
   logic [4:0]  reg_a, reg_b, reg_dst;
   logic [63:0] literal;
   logic        no_rf_upd, use_ltrl_8, use_ltrl_16, use_ltrl_21;
   logic [1:0]  addsub_op, addsub_scale, op_size, mpu_op;
   logic [2:0]  addsub_cmp_op, log_op, log_cmp_op, shmsk_op;
   logic        log_cond_upd, lsu_op, op_llsc, cpr_op;
   logic [3:0]  ctu_op;
   logic        e_reserved, e_halt, e_callpal, hw_ret;
   logic [127:0] got, exp;
   int errors = 0;
   int checks = 0;

   instn_decode_unit dut (
      .clk(clk), .reset(reset), .instn(instn), .funit(funit),
      .reg_a(reg_a), .reg_b(reg_b), .reg_dst(reg_dst), .literal(literal),
      .no_rf_upd(no_rf_upd), .use_ltrl_8(use_ltrl_8), .use_ltrl_16(use_ltrl_16),
      .use_ltrl_21(use_ltrl_21), .addsub_op(addsub_op), .addsub_scale(addsub_scale),
      .addsub_cmp_op(addsub_cmp_op), .log_op(log_op), .log_cmp_op(log_cmp_op),
      .log_cond_upd(log_cond_upd), .ctu_op(ctu_op), .shmsk_op(shmsk_op),
      .op_size(op_size), .mpu_op(mpu_op), .lsu_op(lsu_op), .op_llsc(op_llsc),
      .cpr_op(cpr_op), .e_reserved(e_reserved), .e_halt(e_halt),
      .e_callpal(e_callpal), .hw_ret(hw_ret)
   );

   always #5 clk = ~clk;

   task automatic apply(input logic [31:0] w);
      instn = w;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      instn = 32'h40430405;
      repeat (2) @(posedge clk);
      #1;
      got = {funit, reg_a, reg_b, reg_dst, no_rf_upd};
      exp = {7'd0, 5'd31, 5'd31, 5'd31, 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_regs: got %h want %h", got, exp); end
      got = {literal, use_ltrl_8, use_ltrl_16, use_ltrl_21, addsub_op, addsub_scale, addsub_cmp_op,
             log_op, log_cmp_op, log_cond_upd, ctu_op, shmsk_op, op_size, mpu_op, lsu_op, op_llsc,
             cpr_op, e_reserved, e_halt, e_callpal, hw_ret};
      exp = '0;
      checks++;
      if (got !== exp) begin errors++; $display("FAIL reset_zero: got %h want %h", got, exp); end
      @(negedge clk);
      reset = 1'b1;
      #1;
      got = {funit, reg_dst};
      exp = {7'd0, 5'd31};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL release_hold: got %h want %h", got, exp); end
      @(posedge clk);
      #1;
      got = {funit, reg_dst};
      exp = {7'h01, 5'd5};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL release_first: got %h want %h", got, exp); end
   endtask

   task automatic test_addsub();
      apply(32'h40430405);
      got = {funit, reg_a, reg_b, reg_dst, no_rf_upd, use_ltrl_8, literal};
      exp = {7'h01, 5'd2, 5'd3, 5'd5, 1'b0, 1'b0, 64'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL addq_regs: got %h want %h", got, exp); end
      got = {addsub_op, addsub_scale, op_size, addsub_cmp_op};
      exp = {2'd0, 2'd0, 2'd3, 3'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL addq_ops: got %h want %h", got, exp); end
      apply(32'h401FF449);
      got = {funit, reg_a, reg_dst, use_ltrl_8, literal, addsub_op, addsub_scale, op_size};
      exp = {7'h01, 5'd0, 5'd9, 1'b1, 64'hFF, 2'd0, 2'd1, 2'd3};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL s4addq_lit: got %h want %h", got, exp); end
      apply(32'h401FF049);
      got = {addsub_scale, op_size, use_ltrl_8, literal};
      exp = {2'd1, 2'd2, 1'b1, 64'hFF};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL s4addl_lit: got %h want %h", got, exp); end
      apply(32'h40000767);
      got = {funit, addsub_op, addsub_scale, op_size, reg_dst};
      exp = {7'h01, 2'd1, 2'd2, 2'd3, 5'd7};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL s8subq: got %h want %h", got, exp); end
      apply(32'h400003A1);
      got = {addsub_op, addsub_cmp_op, addsub_scale, op_size, reg_dst};
      exp = {2'd2, 3'd3, 2'd0, 2'd3, 5'd1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL cmpult: got %h want %h", got, exp); end
   endtask

   task automatic test_memory();
      apply(32'hA43EFFF8);
      got = {funit, lsu_op, op_size, op_llsc, reg_dst, no_rf_upd, use_ltrl_16, literal};
      exp = {7'h08, 1'b0, 2'd3, 1'b0, 5'd1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL ldq: got %h want %h", got, exp); end
      apply(32'h24A08000);
      got = {funit, addsub_op, reg_dst, no_rf_upd, use_ltrl_16, literal};
      exp = {7'h01, 2'd3, 5'd5, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_8000};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL ldah: got %h want %h", got, exp); end
      apply(32'hA8600010);
      got = {funit, op_size, op_llsc, reg_dst, literal};
      exp = {7'h08, 2'd2, 1'b1, 5'd3, 64'h10};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL ldl_l: got %h want %h", got, exp); end
      apply(32'hBC410000);
      got = {funit, lsu_op, op_size, op_llsc, reg_dst, no_rf_upd};
      exp = {7'h08, 1'b1, 2'd3, 1'b1, 5'd2, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL stq_c: got %h want %h", got, exp); end
      apply(32'hB4410000);
      got = {funit, lsu_op, op_llsc, reg_dst, no_rf_upd};
      exp = {7'h08, 1'b1, 1'b0, 5'd31, 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL stq: got %h want %h", got, exp); end
      apply(32'h3800007F);
      got = {funit, lsu_op, op_size, reg_dst, no_rf_upd, literal};
      exp = {7'h08, 1'b1, 2'd0, 5'd31, 1'b1, 64'h7F};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL stb: got %h want %h", got, exp); end
   endtask

   task automatic test_branch();
      apply(32'hF43FFFFF);
      got = {funit, ctu_op, no_rf_upd, reg_dst, use_ltrl_21, literal};
      exp = {7'h10, 4'd3, 1'b1, 5'd31, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bne: got %h want %h", got, exp); end
      apply(32'hD3400010);
      got = {funit, ctu_op, no_rf_upd, reg_dst, use_ltrl_21, literal};
      exp = {7'h10, 4'd0, 1'b0, 5'd26, 1'b1, 64'h10};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bsr: got %h want %h", got, exp); end
      apply(32'h6B5B4000);
      got = {funit, ctu_op, no_rf_upd, reg_dst, use_ltrl_16, use_ltrl_21, literal};
      exp = {7'h10, 4'd1, 1'b0, 5'd26, 1'b0, 1'b0, 64'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL jmp: got %h want %h", got, exp); end
      apply(32'hF0200004);
      got = {funit, ctu_op, no_rf_upd, literal};
      exp = {7'h10, 4'd9, 1'b1, 64'h4};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL blbs: got %h want %h", got, exp); end
   endtask

   task automatic test_logical();
      apply(32'h44000483);
      got = {funit, log_op, log_cond_upd, log_cmp_op, reg_dst, no_rf_upd};
      exp = {7'h02, 3'd6, 1'b1, 3'd0, 5'd3, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL cmoveq: got %h want %h", got, exp); end
      apply(32'h44000CC4);
      got = {log_op, log_cond_upd, log_cmp_op, reg_dst};
      exp = {3'd6, 1'b1, 3'd5, 5'd4};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL cmovgt: got %h want %h", got, exp); end
      apply(32'h44000104);
      got = {funit, log_op, log_cond_upd, log_cmp_op};
      exp = {7'h02, 3'd1, 1'b0, 3'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL bic: got %h want %h", got, exp); end
      apply(32'h44101902);
      got = {funit, log_op, use_ltrl_8, literal, reg_dst};
      exp = {7'h02, 3'd5, 1'b1, 64'h80, 5'd2};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL eqv_lit: got %h want %h", got, exp); end
   endtask

   task automatic test_shift_mask();
      apply(32'h48000361);
      got = {funit, shmsk_op, op_size, reg_dst};
      exp = {7'h04, 3'd4, 2'd1, 5'd1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL inswl: got %h want %h", got, exp); end
      apply(32'h48000781);
      got = {funit, shmsk_op, op_size};
      exp = {7'h04, 3'd2, 2'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL sra: got %h want %h", got, exp); end
      apply(32'h48000621);
      got = {funit, shmsk_op, op_size};
      exp = {7'h04, 3'd7, 2'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL zapnot: got %h want %h", got, exp); end
      apply(32'h480006C1);
      got = {funit, shmsk_op, op_size};
      exp = {7'h04, 3'd3, 2'd3};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL extql: got %h want %h", got, exp); end
   endtask

   task automatic test_mpu_cpr();
      apply(32'h4C000601);
      got = {funit, mpu_op, reg_dst, no_rf_upd};
      exp = {7'h20, 2'd2, 5'd1, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL umulh: got %h want %h", got, exp); end
      apply(32'h4C000401);
      got = {funit, mpu_op};
      exp = {7'h20, 2'd1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL mulq: got %h want %h", got, exp); end
      apply(32'h64800000);
      got = {funit, cpr_op, reg_dst, no_rf_upd};
      exp = {7'h40, 1'b0, 5'd4, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL hw_mfpr: got %h want %h", got, exp); end
      apply(32'h74800000);
      got = {funit, cpr_op, reg_dst, no_rf_upd};
      exp = {7'h40, 1'b1, 5'd31, 1'b1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL hw_mtpr: got %h want %h", got, exp); end
      apply(32'h78000000);
      got = {funit, hw_ret, e_reserved, no_rf_upd, reg_dst};
      exp = {7'd0, 1'b1, 1'b0, 1'b1, 5'd31};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL hw_ret: got %h want %h", got, exp); end
   endtask

   task automatic test_pal_reserved();
      apply(32'h00000000);
      got = {funit, e_halt, e_callpal, e_reserved, hw_ret, no_rf_upd, reg_dst};
      exp = {7'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd31};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL halt: got %h want %h", got, exp); end
      apply(32'h00000083);
      got = {funit, e_halt, e_callpal, e_reserved, hw_ret, no_rf_upd, reg_dst};
      exp = {7'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd31};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL callpal: got %h want %h", got, exp); end
      apply(32'h1C000000);
      got = {funit, e_halt, e_callpal, e_reserved, hw_ret, no_rf_upd, reg_dst};
      exp = {7'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'd31};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rsv_opcode: got %h want %h", got, exp); end
      apply(32'h40000020);
      got = {funit, e_reserved, op_size, addsub_op, no_rf_upd, reg_dst};
      exp = {7'd0, 1'b1, 2'd0, 2'd0, 1'b1, 5'd31};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rsv_func: got %h want %h", got, exp); end
      apply(32'hC4000000);
      got = {funit, e_reserved, use_ltrl_21, literal};
      exp = {7'd0, 1'b1, 1'b0, 64'd0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL rsv_fbranch: got %h want %h", got, exp); end
   endtask

   task automatic test_back_to_back();
      apply(32'h40430405);
      @(negedge clk);
      instn = 32'hA43EFFF8;
      #1;
      got = {funit, reg_dst};
      exp = {7'h01, 5'd5};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_hold: got %h want %h", got, exp); end
      @(posedge clk);
      #1;
      got = {funit, reg_dst};
      exp = {7'h08, 5'd1};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_ldq: got %h want %h", got, exp); end
      apply(32'hF43FFFFF);
      got = {funit, ctu_op, reg_dst};
      exp = {7'h10, 4'd3, 5'd31};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL b2b_bne: got %h want %h", got, exp); end
   endtask

   task automatic test_async_reset();
      apply(32'h40430405);
      #2;
      reset = 1'b0;
      #1;
      got = {funit, reg_a, reg_b, reg_dst, no_rf_upd, e_reserved};
      exp = {7'd0, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL async_reset: got %h want %h", got, exp); end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      got = {funit, reg_dst, no_rf_upd};
      exp = {7'h01, 5'd5, 1'b0};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL async_release: got %h want %h", got, exp); end
   endtask

   initial begin
      test_reset();
      test_addsub();
      test_memory();
      test_branch();
      test_logical();
      test_shift_mask();
      test_mpu_cpr();
      test_pal_reserved();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
